rv32i_hazard_sched: RTL

//  Hazard controller and regfile write-port arbiter for the 5-stage RV32I pipeline.

---
 rtl/rv32i_hazard_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rv32i_hazard_sched.sv
// Hazard controller, long-op scoreboard and regfile write-port arbiter for a 5-stage RV32I pipeline.
// Optional HAZARD_PERF_EN adds StallCyc/StarveCyc performance counters.
module rv32i_hazard_sched #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic       LongD,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic       LongIssueE,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LongValid,
  input  logic [4:0] LongRd,
  output logic       LongGnt,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic [4:0] PendCnt,
  output logic       SbErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCyc,
  output logic [31:0] StarveCyc
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [4:0]    MAX_C    = 5'(MAX_OUT);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [31:0]   sb_q, sb_d;
  logic [4:0]    pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic          gnt_s, lw_stall_s, sb_stall_s, starve_s, hold_s;

  // M stage beats W/long write-back so the youngest value is used.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw,
                                         input logic lg, input logic [4:0] lrd);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs == 5'd0) begin
      sel = 2'b00;
    end else if (wm && (rdm == rs)) begin
      sel = 2'b10;
    end else if ((ww && (rdw == rs)) || (lg && (lrd == rs))) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign gnt_s      = LongValid && !RegWriteW;
  assign starve_s   = (starve_q >= STARVE_C);
  assign lw_stall_s = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign sb_stall_s = ((Rs1D != 5'd0) && sb_q[Rs1D]) || ((Rs2D != 5'd0) && sb_q[Rs2D])
                    || (RegWriteD && (RdD != 5'd0) && sb_q[RdD])
                    || (LongIssueE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == RdD)))
                    || (LongD && (pend_q == MAX_C));
  assign hold_s     = lw_stall_s || sb_stall_s || starve_s;

  // Pipeline controls; a resolved redirect squashes D instead of stalling it.
  always_comb begin
    LongGnt   = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      LongGnt   = gnt_s;
      StallF    = hold_s && !PCSrcE;
      StallD    = hold_s && !PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = hold_s || PCSrcE;
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW, gnt_s, LongRd);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW, gnt_s, LongRd);
    end else begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Scoreboard, outstanding count and starvation tracking; issue to a reg wins over its completion.
  always_comb begin
    sb_d     = sb_q;
    pend_d   = pend_q;
    err_d    = err_q;
    starve_d = starve_q;
    if (gnt_s) begin
      sb_d[LongRd] = 1'b0;
    end else begin
      sb_d = sb_q;
    end
    if (LongIssueE && (RdE != 5'd0)) begin
      sb_d[RdE] = 1'b1;
    end else begin
      sb_d[0] = 1'b0;
    end
    case ({LongIssueE, gnt_s})
      2'b10:   pend_d = (pend_q == MAX_C) ? pend_q : pend_q + 5'd1;
      2'b01: begin
        if (pend_q == 5'd0) begin
          err_d = 1'b1;
        end else begin
          pend_d = pend_q - 5'd1;
        end
      end
      default: pend_d = pend_q;
    endcase
    if (!LongValid || gnt_s) begin
      starve_d = '0;
    end else if (starve_q < STARVE_C) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q     <= 32'd0;
      pend_q   <= 5'd0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sb_q     <= sb_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign PendCnt = pend_q;
  assign SbErr   = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc_q, starve_cyc_q;

  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q  <= 32'd0;
      starve_cyc_q <= 32'd0;
    end else begin
      stall_cyc_q  <= stall_cyc_q + {31'd0, StallD};
      starve_cyc_q <= starve_cyc_q + {31'd0, starve_s};
    end
  end

  assign StallCyc  = stall_cyc_q;
  assign StarveCyc = starve_cyc_q;
`endif

endmodule
